hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised hazard unit for the 5-stage pipeline (F/D/E/M/W): generates per-operand forwarding selects, load-use stalls, branch/PC-write flushes, multi-cycle execute (multiply) occupancy, and data-memory wait stalls. It sits beside the datapath in the same place as the current single-cycle hazard logic. It adds:
- `NREAD` forwarded operands in E;
- a sequential occupancy counter for `MUL_CYCLES`-long E-stage operations;
- whole-pipe freeze on memory wait;
- a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- NREAD, 3, number of E-stage source operands with forwarding (Rn, Rm, Rs)
- MUL_CYCLES, 4, cycles a multi-cycle op occupies E (≥1; 1 = no extra stall)
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- BranchTakenD  in  1  branch resolved taken in D
- MemtoRegE  in  1  E instruction is a load
- RegWriteM, RegWriteW  in  1  M/W instruction writes register file
- PCSrcW  in  1  W instruction writes PC
- PCWrPendingF  in  1  PC write in flight in D/E/M
- Match_E_M  in  NREAD  bit i: E operand i matches M destination
- Match_E_W  in  NREAD  bit i: E operand i matches W destination
- Match_D_E  in  1  any D source matches E destination
- MulStartE  in  1  E holds a multi-cycle op
- MemStallM  in  1  data memory not ready; M must hold
- Forward  out  2*NREAD  bits [2i+1:2i] = select for operand i
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1  clear stage register (bubble)
- MulBusyE  out  1  E occupied by unfinished multi-cycle op
- StallCount  out  CNT_W  saturating count of cycles with StallF=1

## Operation
- Forward field i: 2'b10 if Match_E_M[i]&RegWriteM; else 2'b01 if Match_E_W[i]&RegWriteW; else 2'b00. M has priority. Purely combinational; valid during stalls.
- Occupancy counter cnt, width $clog2(MUL_CYCLES) (min 1), reset 0.
  - MulBusyE = (MulStartE & cnt==0 & MUL_CYCLES>1) | (cnt>1).
  - On clock, when MemStallM=0:
    - MulStartE & cnt==0 & MUL_CYCLES>1: cnt ← MUL_CYCLES-1.
    - Else, if cnt≠0: cnt ← cnt-1.
  - When MemStallM=1: cnt holds.
- ldrStall = Match_D_E & MemtoRegE & ~MulBusyE.
- Stalls and flushes:
  - StallM = MemStallM.
  - StallE = MemStallM | MulBusyE.
  - StallD = StallE | ldrStall.
  - StallF = StallD | PCWrPendingF.
  - FlushW = MemStallM.
  - FlushM = MulBusyE & ~MemStallM.
  - FlushE = ldrStall & ~StallE.
  - FlushD = PCSrcW | ((PCWrPendingF | BranchTakenD) & ~StallE).
- Flush overrides stall at a stage register: a PC redirect from W clears D even during a freeze.
- StallCount increments each cycle StallF=1; saturates at all-ones; reset 0.

## Timing
- Reset asserted: cnt=0 and StallCount=0 immediately (asynchronous).
  - Combinational outputs then follow the inputs with MulBusyE = MulStartE & (MUL_CYCLES>1).
  - With all inputs 0, every output is 0.
- All stall/flush/forward outputs are combinational, same cycle as inputs. No registered-output latency.
- Multi-cycle op with MUL_CYCLES=N (N>1) and no memory stall:
  - It resides in E exactly N cycles; MulBusyE=1 for cycles 1..N-1 and 0 in cycle N.
  - FlushM=1 for N-1 cycles, giving N-1 bubbles in M.
  - Back-to-back multi-cycle ops: the next op sees cnt==0 on its first E cycle and restarts.
- MemStallM mid-multiply: cnt freezes, so total E residency = N + number of MemStallM cycles.
- Load-use: 1 stall cycle (StallF/StallD/FlushE) when E is not busy. While E is stalled it is suppressed, so the load is never flushed from E.
- Reset mid-operation clears cnt. An instruction left in E with MulStartE=1 restarts a full N-cycle occupancy.

## Test plan
- Forwarding, NREAD=3: Match_E_M=3'b011, Match_E_W=3'b110, RegWriteM=RegWriteW=1 -> Forward=6'b01_10_10. Same with RegWriteM=0 -> 6'b01_01_00.
- MUL_CYCLES=4, MulStartE held for 4 cycles -> MulBusyE/StallE/FlushM = 1,1,1,0; cnt = 0→3→2→1→0. MUL_CYCLES=1 -> never busy.
- Load-use: Match_D_E=1, MemtoRegE=1 -> StallF=StallD=FlushE=1 for one cycle, StallE=0. Repeat during MulBusyE -> FlushE=0.
- MemStallM=1 for 2 cycles during multiply cycle 2 -> StallF..StallM=1, FlushW=1, FlushM=0, cnt holds at 3; busy ends 2 cycles later. BranchTakenD during freeze -> FlushD=0. PCSrcW during freeze -> FlushD=1.
- Reset asserted with cnt=2 -> cnt and StallCount become 0 without a clock edge.
- CNT_W=4, StallF held 20 cycles -> StallCount = 15 and stays at 15.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: operand forwarding, load-use/multi-cycle/memory-wait stalls, flushes, stall counter.
// Stall/flush/forward outputs are combinational; only the multiply occupancy and stall counter are registered.
module hazard_unit_mc #(
    parameter int NREAD      = 3,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 BranchTakenD,
    input  logic                 MemtoRegE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcW,
    input  logic                 PCWrPendingF,
    input  logic [NREAD-1:0]     Match_E_M,
    input  logic [NREAD-1:0]     Match_E_W,
    input  logic                 Match_D_E,
    input  logic                 MulStartE,
    input  logic                 MemStallM,
    output logic [2*NREAD-1:0]   Forward,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 FlushW,
    output logic                 MulBusyE,
    output logic [CNT_W-1:0]     StallCount
);

    localparam int            CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic          MULTI    = (MUL_CYCLES > 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_ldr_stall;
    logic             w_stall_e;
    logic             w_stall_d;
    logic             w_stall_f;

    // M-stage result wins over W-stage when both match the same operand.
    always_comb begin
        Forward = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (Match_E_M[i] & RegWriteM)
                Forward[2*i +: 2] = 2'b10;
            else if (Match_E_W[i] & RegWriteW)
                Forward[2*i +: 2] = 2'b01;
        end
    end

    assign w_mul_start = MulStartE & (r_cnt == '0) & MULTI;
    assign w_mul_busy  = w_mul_start | ({1'b0, r_cnt} > (CW+1)'(1));
    assign w_ldr_stall = Match_D_E & MemtoRegE & ~w_mul_busy;

    assign w_stall_e = MemStallM | w_mul_busy;
    assign w_stall_d = w_stall_e | w_ldr_stall;
    assign w_stall_f = w_stall_d | PCWrPendingF;

    assign StallM   = MemStallM;
    assign StallE   = w_stall_e;
    assign StallD   = w_stall_d;
    assign StallF   = w_stall_f;
    assign FlushW   = MemStallM;
    assign FlushM   = w_mul_busy & ~MemStallM;
    assign FlushE   = w_ldr_stall & ~w_stall_e;
    // A W-stage PC redirect clears D even while the pipe is frozen.
    assign FlushD   = PCSrcW | ((PCWrPendingF | BranchTakenD) & ~w_stall_e);
    assign MulBusyE = w_mul_busy;

    // Occupancy freezes with the rest of the pipe on a memory wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!MemStallM) begin
            if (w_mul_start)
                r_cnt <= CNT_LOAD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_stall_f && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign StallCount = r_stall_cnt;

endmodule
